// File: rtl/cpu_pkg.sv
// Shared core types: datapath constants, the EX control bundle and the
// ID/EX pipeline register payload, including the canonical bubble value.
package cpu_pkg;

  localparam int REG_SIZE = 5;
  localparam int DATA_W   = 32;
  localparam int ALUOP_W  = 4;

  typedef struct packed {
    logic               regWrite;
    logic               memToReg;
    logic               memWrite;
    logic               aluSrc;
    logic               branch;
    logic [ALUOP_W-1:0] aluOp;
  } ctrl_t;

  typedef struct packed {
    logic                valid;
    ctrl_t               ctrl;
    logic [REG_SIZE-1:0] raddr1;
    logic [REG_SIZE-1:0] raddr2;
    logic [REG_SIZE-1:0] writeReg;
    logic [DATA_W-1:0]   rdata1;
    logic [DATA_W-1:0]   rdata2;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   pc;
  } ex_bundle_t;

  // An all-zero bundle: no valid, no writeback, no memory access, zero
  // addresses so the forwarding unit never matches against it.
  localparam ex_bundle_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags a D-stage instruction that
// reads the destination of a load currently sitting in E. Register 0 is
// hard-wired zero and never creates a dependency.
module load_use_detect #(
  parameter int REG_SIZE = cpu_pkg::REG_SIZE
) (
  input  logic                validE,
  input  logic                memToRegE,
  input  logic [REG_SIZE-1:0] writeRegE,
  input  logic                validD,
  input  logic [REG_SIZE-1:0] raddr1D,
  input  logic [REG_SIZE-1:0] raddr2D,
  input  logic                useRs1D,
  input  logic                useRs2D,
  output logic                loadUse
);

  logic w_loadInE;
  logic w_rs1Hit;
  logic w_rs2Hit;

  assign w_loadInE = validE & memToRegE & (writeRegE != '0);
  assign w_rs1Hit  = useRs1D & (raddr1D == writeRegE);
  assign w_rs2Hit  = useRs2D & (raddr2D == writeRegE);

  // Hazard only when both stages hold real instructions and a used source matches.
  always_comb begin
    loadUse = w_loadInE & validD & (w_rs1Hit | w_rs2Hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, redirect flush and memory
// hold handling. Priority per edge: hold > redirect > load-use > advance.
// Also keeps a saturating count of bubbles inserted over real instructions.
module id_ex_stage #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int REG_SIZE = cpu_pkg::REG_SIZE,
  parameter int ALUOP_W  = cpu_pkg::ALUOP_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                validD,
  input  logic [REG_SIZE-1:0] raddr1D,
  input  logic [REG_SIZE-1:0] raddr2D,
  input  logic                useRs1D,
  input  logic                useRs2D,
  input  logic [REG_SIZE-1:0] writeRegD,
  input  logic [DATA_W-1:0]   rdata1D,
  input  logic [DATA_W-1:0]   rdata2D,
  input  logic [DATA_W-1:0]   immD,
  input  logic [DATA_W-1:0]   pcD,
  input  logic                regWriteD,
  input  logic                memToRegD,
  input  logic                memWriteD,
  input  logic                aluSrcD,
  input  logic                branchD,
  input  logic [ALUOP_W-1:0]  aluOpD,
  input  logic                redirectE,
  input  logic                holdM,
  output logic                validE,
  output logic [REG_SIZE-1:0] raddr1E,
  output logic [REG_SIZE-1:0] raddr2E,
  output logic [REG_SIZE-1:0] writeRegE,
  output logic [DATA_W-1:0]   rdata1E,
  output logic [DATA_W-1:0]   rdata2E,
  output logic [DATA_W-1:0]   immE,
  output logic [DATA_W-1:0]   pcE,
  output logic                regWriteE,
  output logic                memToRegE,
  output logic                memWriteE,
  output logic                aluSrcE,
  output logic                branchE,
  output logic [ALUOP_W-1:0]  aluOpE,
  output logic                stallF,
  output logic                stallD,
  output logic                flushD,
  output logic [CNT_W-1:0]    bubbleCnt
);

  import cpu_pkg::ex_bundle_t;
  import cpu_pkg::BUBBLE;

  ex_bundle_t       r_ex;
  ex_bundle_t       w_exD;
  logic [CNT_W-1:0] r_bubbleCnt;
  logic             w_loadUse;
  logic             w_bubble;
  logic             w_cntInc;

  load_use_detect #(
    .REG_SIZE (REG_SIZE)
  ) u_load_use_detect (
    .validE    (r_ex.valid),
    .memToRegE (r_ex.ctrl.memToReg),
    .writeRegE (r_ex.writeReg),
    .validD    (validD),
    .raddr1D   (raddr1D),
    .raddr2D   (raddr2D),
    .useRs1D   (useRs1D),
    .useRs2D   (useRs2D),
    .loadUse   (w_loadUse)
  );

  // Pack the decoded D-stage fields into the EX bundle format.
  always_comb begin
    w_exD               = BUBBLE;
    w_exD.valid         = validD;
    w_exD.ctrl.regWrite = regWriteD;
    w_exD.ctrl.memToReg = memToRegD;
    w_exD.ctrl.memWrite = memWriteD;
    w_exD.ctrl.aluSrc   = aluSrcD;
    w_exD.ctrl.branch   = branchD;
    w_exD.ctrl.aluOp    = aluOpD;
    w_exD.raddr1        = raddr1D;
    w_exD.raddr2        = raddr2D;
    w_exD.writeReg      = writeRegD;
    w_exD.rdata1        = rdata1D;
    w_exD.rdata2        = rdata2D;
    w_exD.imm           = immD;
    w_exD.pc            = pcD;
  end

  // A redirect kills D, so a coincident load-use is void and no stall is raised.
  always_comb begin
    stallF   = holdM | (w_loadUse & ~redirectE);
    stallD   = holdM | (w_loadUse & ~redirectE);
    flushD   = redirectE & ~holdM;
    w_bubble = ~holdM & (redirectE | w_loadUse);
    w_cntInc = w_bubble & validD & (r_bubbleCnt != {CNT_W{1'b1}});
  end

  // E register: hold on memory stall, bubble on redirect/load-use, else advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= BUBBLE;
    end else if (holdM) begin
      r_ex <= r_ex;
    end else if (w_bubble) begin
      r_ex <= BUBBLE;
    end else begin
      r_ex <= w_exD;
    end
  end

  // Saturating count of bubbles inserted while D held a real instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubbleCnt <= '0;
    end else if (w_cntInc) begin
      r_bubbleCnt <= r_bubbleCnt + 1'b1;
    end
  end

  assign validE    = r_ex.valid;
  assign raddr1E   = r_ex.raddr1;
  assign raddr2E   = r_ex.raddr2;
  assign writeRegE = r_ex.writeReg;
  assign rdata1E   = r_ex.rdata1;
  assign rdata2E   = r_ex.rdata2;
  assign immE      = r_ex.imm;
  assign pcE       = r_ex.pc;
  assign regWriteE = r_ex.ctrl.regWrite;
  assign memToRegE = r_ex.ctrl.memToReg;
  assign memWriteE = r_ex.ctrl.memWrite;
  assign aluSrcE   = r_ex.ctrl.aluSrc;
  assign branchE   = r_ex.ctrl.branch;
  assign aluOpE    = r_ex.ctrl.aluOp;
  assign bubbleCnt = r_bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, r0/unused-source
// exemptions, redirect priority, memory hold and counter saturation.
module tb_id_ex_stage;

  localparam int DATA_W   = 32;
  localparam int REG_SIZE = 5;
  localparam int ALUOP_W  = 4;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                validD;
  logic [REG_SIZE-1:0] raddr1D, raddr2D, writeRegD;
  logic                useRs1D, useRs2D;
  logic [DATA_W-1:0]   rdata1D, rdata2D, immD, pcD;
  logic                regWriteD, memToRegD, memWriteD, aluSrcD, branchD;
  logic [ALUOP_W-1:0]  aluOpD;
  logic                redirectE, holdM;
  logic                validE;
  logic [REG_SIZE-1:0] raddr1E, raddr2E, writeRegE;
  logic [DATA_W-1:0]   rdata1E, rdata2E, immE, pcE;
  logic                regWriteE, memToRegE, memWriteE, aluSrcE, branchE;
  logic [ALUOP_W-1:0]  aluOpE;
  logic                stallF, stallD, flushD;
  logic [CNT_W-1:0]    bubbleCnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(
    .DATA_W(DATA_W), .REG_SIZE(REG_SIZE), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .validD(validD),
    .raddr1D(raddr1D), .raddr2D(raddr2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .writeRegD(writeRegD), .rdata1D(rdata1D), .rdata2D(rdata2D), .immD(immD), .pcD(pcD),
    .regWriteD(regWriteD), .memToRegD(memToRegD), .memWriteD(memWriteD),
    .aluSrcD(aluSrcD), .branchD(branchD), .aluOpD(aluOpD),
    .redirectE(redirectE), .holdM(holdM),
    .validE(validE), .raddr1E(raddr1E), .raddr2E(raddr2E), .writeRegE(writeRegE),
    .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE), .pcE(pcE),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
    .aluSrcE(aluSrcE), .branchE(branchE), .aluOpE(aluOpE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .bubbleCnt(bubbleCnt)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a D-stage instruction; data fields derived from addresses so they are recognisable.
  task automatic drive_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic is_load, input logic wr);
    validD    = v;
    raddr1D   = rs1;
    raddr2D   = rs2;
    useRs1D   = u1;
    useRs2D   = u2;
    writeRegD = rd;
    rdata1D   = 32'h1000 + 32'(rs1);
    rdata2D   = 32'h2000 + 32'(rs2);
    immD      = 32'h30 + 32'(rd);
    pcD       = 32'h400 + 32'(rd) * 4;
    regWriteD = wr;
    memToRegD = is_load;
    memWriteD = 1'b0;
    aluSrcD   = is_load;
    branchD   = 1'b0;
    aluOpD    = is_load ? 4'h2 : 4'h1;
  endtask

  task automatic do_reset();
    redirectE = 1'b0;
    holdM     = 1'b0;
    drive_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    // Put a live instruction in E, then pull reset in the middle of a cycle.
    do_reset();
    drive_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (validE !== 1'b0) begin n_bad++; $display("FAIL reset_validE got %0b exp 0", validE); end
    n_cmp++; if (writeRegE !== 5'd0) begin n_bad++; $display("FAIL reset_writeRegE got %0d exp 0", writeRegE); end
    n_cmp++; if (rdata1E !== 32'd0) begin n_bad++; $display("FAIL reset_rdata1E got %0h exp 0", rdata1E); end
    n_cmp++; if (memToRegE !== 1'b0) begin n_bad++; $display("FAIL reset_memToRegE got %0b exp 0", memToRegE); end
    n_cmp++; if ({stallF, stallD, flushD} !== 3'b000) begin n_bad++; $display("FAIL reset_stall_flush got %b exp 000", {stallF, stallD, flushD}); end
    n_cmp++; if (bubbleCnt !== 4'd0) begin n_bad++; $display("FAIL reset_bubbleCnt got %0d exp 0", bubbleCnt); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
    #1;
    n_cmp++; if (stallF !== 1'b0) begin n_bad++; $display("FAIL post_reset_stallF got %0b exp 0", stallF); end
    step();
    n_cmp++; if (validE !== 1'b1) begin n_bad++; $display("FAIL post_reset_validE got %0b exp 1", validE); end
    n_cmp++; if (writeRegE !== 5'd3) begin n_bad++; $display("FAIL post_reset_writeRegE got %0d exp 3", writeRegE); end
    n_cmp++; if (rdata2E !== 32'h2002) begin n_bad++; $display("FAIL post_reset_rdata2E got %0h exp 2002", rdata2E); end
    n_cmp++; if (pcE !== 32'h40C) begin n_bad++; $display("FAIL post_reset_pcE got %0h exp 40c", pcE); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_d(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);  // lw r5
    step();
    drive_d(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);  // add r6,r5,r1
    #1;
    n_cmp++; if ({stallF, stallD} !== 2'b11) begin n_bad++; $display("FAIL lu_stall got %b exp 11", {stallF, stallD}); end
    n_cmp++; if (flushD !== 1'b0) begin n_bad++; $display("FAIL lu_flushD got %0b exp 0", flushD); end
    step();
    n_cmp++; if (validE !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_validE got %0b exp 0", validE); end
    n_cmp++; if (regWriteE !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_regWriteE got %0b exp 0", regWriteE); end
    n_cmp++; if (writeRegE !== 5'd0) begin n_bad++; $display("FAIL lu_bubble_writeRegE got %0d exp 0", writeRegE); end
    n_cmp++; if (bubbleCnt !== 4'd1) begin n_bad++; $display("FAIL lu_bubbleCnt got %0d exp 1", bubbleCnt); end
    n_cmp++; if (stallF !== 1'b0) begin n_bad++; $display("FAIL lu_stall_release got %0b exp 0", stallF); end
    step();
    n_cmp++; if (validE !== 1'b1) begin n_bad++; $display("FAIL lu_reenter_validE got %0b exp 1", validE); end
    n_cmp++; if (raddr1E !== 5'd5) begin n_bad++; $display("FAIL lu_reenter_raddr1E got %0d exp 5", raddr1E); end
    n_cmp++; if (writeRegE !== 5'd6) begin n_bad++; $display("FAIL lu_reenter_writeRegE got %0d exp 6", writeRegE); end
    n_cmp++; if (rdata1E !== 32'h1005) begin n_bad++; $display("FAIL lu_reenter_rdata1E got %0h exp 1005", rdata1E); end
    n_cmp++; if (bubbleCnt !== 4'd1) begin n_bad++; $display("FAIL lu_cnt_after got %0d exp 1", bubbleCnt); end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw r0
    step();
    drive_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);  // lw r7 reading r0
    #1;
    n_cmp++; if (stallF !== 1'b0) begin n_bad++; $display("FAIL r0_stallF got %0b exp 0", stallF); end
    step();
    n_cmp++; if (writeRegE !== 5'd7) begin n_bad++; $display("FAIL r0_advance_writeRegE got %0d exp 7", writeRegE); end
    drive_d(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd8, 1'b0, 1'b1);  // rs2=r7 but unused
    #1;
    n_cmp++; if (stallD !== 1'b0) begin n_bad++; $display("FAIL unused_rs2_stallD got %0b exp 0", stallD); end
    useRs2D = 1'b1;
    #1;
    n_cmp++; if (stallD !== 1'b1) begin n_bad++; $display("FAIL used_rs2_stallD got %0b exp 1", stallD); end
    useRs2D = 1'b0;
    step();
    n_cmp++; if (bubbleCnt !== 4'd0) begin n_bad++; $display("FAIL no_stall_cnt got %0d exp 0", bubbleCnt); end
  endtask

  task automatic test_redirect_vs_load_use();
    do_reset();
    drive_d(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);  // lw r5
    step();
    drive_d(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1);  // dependent add
    redirectE = 1'b1;
    #1;
    n_cmp++; if (stallF !== 1'b0) begin n_bad++; $display("FAIL redir_stallF got %0b exp 0", stallF); end
    n_cmp++; if (flushD !== 1'b1) begin n_bad++; $display("FAIL redir_flushD got %0b exp 1", flushD); end
    step();
    redirectE = 1'b0;
    n_cmp++; if (validE !== 1'b0) begin n_bad++; $display("FAIL redir_validE got %0b exp 0", validE); end
    n_cmp++; if (bubbleCnt !== 4'd1) begin n_bad++; $display("FAIL redir_cnt got %0d exp 1", bubbleCnt); end
    drive_d(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 1'b0, 1'b1);
    step();
    n_cmp++; if (writeRegE !== 5'd11) begin n_bad++; $display("FAIL redir_next_writeRegE got %0d exp 11", writeRegE); end
    n_cmp++; if (bubbleCnt !== 4'd1) begin n_bad++; $display("FAIL redir_next_cnt got %0d exp 1", bubbleCnt); end
  endtask

  task automatic test_hold();
    do_reset();
    drive_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);  // add r3
    step();
    drive_d(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1);
    holdM     = 1'b1;
    redirectE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (flushD !== 1'b0) begin n_bad++; $display("FAIL hold_flushD cyc %0d got %0b exp 0", i, flushD); end
      n_cmp++; if (stallF !== 1'b1) begin n_bad++; $display("FAIL hold_stallF cyc %0d got %0b exp 1", i, stallF); end
      step();
      n_cmp++; if (writeRegE !== 5'd3 || validE !== 1'b1) begin n_bad++; $display("FAIL hold_keep cyc %0d got rd=%0d v=%0b exp rd=3 v=1", i, writeRegE, validE); end
      n_cmp++; if (bubbleCnt !== 4'd0) begin n_bad++; $display("FAIL hold_cnt cyc %0d got %0d exp 0", i, bubbleCnt); end
    end
    holdM = 1'b0;
    #1;
    n_cmp++; if (flushD !== 1'b1) begin n_bad++; $display("FAIL hold_release_flushD got %0b exp 1", flushD); end
    n_cmp++; if (stallF !== 1'b0) begin n_bad++; $display("FAIL hold_release_stallF got %0b exp 0", stallF); end
    step();
    redirectE = 1'b0;
    n_cmp++; if (validE !== 1'b0 || writeRegE !== 5'd0) begin n_bad++; $display("FAIL hold_release_bubble got v=%0b rd=%0d exp v=0 rd=0", validE, writeRegE); end
    n_cmp++; if (bubbleCnt !== 4'd1) begin n_bad++; $display("FAIL hold_release_cnt got %0d exp 1", bubbleCnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    // lw r5 that reads r5: alternates load, bubble, load, bubble ...
    drive_d(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step();
      step();
      if (i == 13) begin
        n_cmp++; if (bubbleCnt !== 4'd14) begin n_bad++; $display("FAIL sat_cnt14 got %0d exp 14", bubbleCnt); end
      end
    end
    n_cmp++; if (bubbleCnt !== 4'd15) begin n_bad++; $display("FAIL sat_cnt_final got %0d exp 15", bubbleCnt); end
    n_cmp++; if (validE !== 1'b0) begin n_bad++; $display("FAIL sat_last_bubble got %0b exp 0", validE); end
  endtask

  initial begin
    rst_n = 1'b0;
    redirectE = 1'b0;
    holdM     = 1'b0;
    drive_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
    #3;
    n_cmp++; if (validE !== 1'b0 || bubbleCnt !== 4'd0) begin n_bad++; $display("FAIL initial_reset got v=%0b cnt=%0d exp 0 0", validE, bubbleCnt); end
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect_vs_load_use();
    test_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
